// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic [31:0] acc;      // partial product high half / running remainder
  logic [31:0] mq;       // multiplier being shifted out / dividend shifted into quotient
  logic [31:0] opnd;     // multiplicand or divisor magnitude
  logic        neg_q;    // negate product or quotient at commit
  logic        neg_r;    // negate remainder at commit

  // Operand sign handling: op[0]=0 selects the signed variants
  logic        sgn_ops, sa, sb;
  logic [31:0] abs_a, abs_b;
  assign sgn_ops = ~op[0];
  assign sa      = sgn_ops & a[31];
  assign sb      = sgn_ops & b[31];
  assign abs_a   = sa ? (32'd0 - a) : a;
  assign abs_b   = sb ? (32'd0 - b) : b;

  // One shared 33-bit adder: add multiplicand for multiply, subtract divisor for divide
  logic [32:0] rem_sh, add_x, add_y, sum;
  logic [31:0] nxt_acc, nxt_mq;
  assign rem_sh = {acc, mq[31]};
  assign add_x  = is_div ? rem_sh : {1'b0, acc};
  assign add_y  = is_div ? ~{1'b0, opnd} : (mq[0] ? {1'b0, opnd} : 33'd0);
  assign sum    = add_x + add_y + {32'd0, is_div};

  // Next partial state: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    nxt_acc = acc;
    nxt_mq  = mq;
    if (is_div) begin
      nxt_acc = sum[32] ? rem_sh[31:0] : sum[31:0];
      nxt_mq  = {mq[30:0], ~sum[32]};
    end else begin
      nxt_acc = sum[32:1];
      nxt_mq  = {sum[0], mq[31:1]};
    end
  end

  // Sign fix-up of the final step's result
  logic [63:0] prod, prod_fix;
  logic [31:0] quot_fix, rem_fix, res_hi, res_lo;
  assign prod     = {nxt_acc, nxt_mq};
  assign prod_fix = neg_q ? (64'd0 - prod) : prod;
  assign quot_fix = neg_q ? (32'd0 - nxt_mq) : nxt_mq;
  assign rem_fix  = neg_r ? (32'd0 - nxt_acc) : nxt_acc;
  assign res_hi   = is_div ? rem_fix  : prod_fix[63:32];
  assign res_lo   = is_div ? quot_fix : prod_fix[31:0];

  logic launch, commit;
  assign launch = (state == IDLE) && start && !flush;
  assign commit = (state == RUN) && !flush && (cnt == 5'd31);
  assign busy   = (state == RUN);

  // Sequencer and iteration datapath; flush abandons the operation without committing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      done   <= 1'b0;
      is_div <= 1'b0;
      acc    <= 32'd0;
      mq     <= 32'd0;
      opnd   <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= commit;
      if (launch) begin
        state  <= RUN;
        cnt    <= 5'd0;
        is_div <= op[1];
        acc    <= 32'd0;
        mq     <= op[1] ? abs_a : abs_b;
        opnd   <= op[1] ? abs_b : abs_a;
        // Divide by zero keeps the all-ones quotient regardless of dividend sign
        neg_q  <= (sa ^ sb) && !(op[1] && (b == 32'd0));
        neg_r  <= op[1] & sa;
      end else if (state == RUN) begin
        if (flush) begin
          state <= IDLE;
        end else begin
          acc <= nxt_acc;
          mq  <= nxt_mq;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= IDLE;
        end
      end
    end
  end

  // Architectural HI/LO: result commit or mthi/mtlo writes while idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state == IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  int          checks = 0;
  int          failures = 0;
  int          done_count = 0;
  logic [31:0] last_hi, last_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int    sx, sy, q, r;
    longint p;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        p = longint'(sx) * longint'(sy);
        return p;
      end
      2'b01: return {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resetn && done) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%0h_%0h required=no_done", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hilo", {hi, lo}, {e.hi, e.lo});
      end
    end
  end

  // Launch one operation, optionally poking start/write strobes mid-run or writing alongside start
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int poke, input bit wr);
    int cycles;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (wr) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA5555; end
    sb.push_back('{hi: eh, lo: el});
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    if (wr) begin
      chk("write_with_start", {hi, lo}, {32'hAAAA5555, 32'hAAAA5555});
      last_hi = 32'hAAAA5555;
      last_lo = 32'hAAAA5555;
    end
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      if (cycles == poke) begin
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
      if (cycles == poke) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("busy_write_ignored", {hi, lo}, {last_hi, last_lo});
      end
    end
    chk("busy_cycles", 64'(cycles), 64'd32);
    chk("done_pulse", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    last_hi = eh;
    last_lo = el;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dc;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    logic [63:0] rr;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
    vecs[5]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[9]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{2'b00, 32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000};

    resetn = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    last_hi = 32'd0;
    last_lo = 32'd0;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      rr = ref_model(ro, rx, ry);
      run_op(ro, rx, ry, rr[63:32], rr[31:0], -1, 1'b0);
    end

    // Write strobe together with start: write lands first, result overwrites later
    run_op(2'b00, 32'd6, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4, -1, 1'b1);

    // Start and flush in the same idle cycle are ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_ignored", {63'd0, busy}, 64'd0);

    // Preset via mthi/mtlo, then flush a multiply mid-run
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("preset_hilo", {hi, lo}, {32'h12345678, 32'h12345678});
    last_hi = 32'h12345678;
    last_lo = 32'h12345678;
    dc = done_count;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_hilo", {hi, lo}, {32'h12345678, 32'h12345678});
    repeat (30) @(posedge clk);
    #1;
    chk("flush_no_done", 64'(done_count), 64'(dc));
    chk("flush_hilo_later", {hi, lo}, {32'h12345678, 32'h12345678});

    // Start and write strobes during busy have no effect on result or latency
    run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b0);

    // Asynchronous reset in the middle of a divu
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd1000000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_done", {63'd0, done}, 64'd0);
    chk("midreset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    last_hi = 32'd0;
    last_lo = 32'd0;
    run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, -1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock, clk, with reset resetn asynchronous and active-low; all state SHALL update on the rising edge of clk.
REQ-002 Ports (name  direction  width  meaning):
 clk  in  1  clock
 resetn  in  1  async active-low reset
 start  in  1  request a new operation
 op  in  2  00 mult, 01 multu, 10 div, 11 divu
 a  in  32  rs operand (multiplicand / dividend)
 b  in  32  rt operand (multiplier / divisor)
 flush  in  1  cancel the in-flight operation
 hi_we  in  1  mthi write strobe
 lo_we  in  1  mtlo write strobe
 wdata  in  32  mthi/mtlo data
 busy  out  1  operation in flight; pipeline stalls mfhi/mflo/new muldiv
 done  out  1  one-cycle result-committed pulse
 hi  out  32  HI register
 lo  out  32  LO register

Function
REQ-003 The block SHALL implement FSM states IDLE and RUN; busy SHALL equal (state == RUN).
REQ-004 In IDLE with start=1 and flush=0, the block SHALL latch op, |a| and |b| (signed ops) or a and b (unsigned ops), and the result signs, then enter RUN with iteration count = 0.
REQ-005 start SHALL be ignored while busy=1; start and flush in the same IDLE cycle SHALL be ignored.
REQ-006 RUN SHALL perform one radix-2 step per cycle using a single 33-bit add/subtract: shift-add for multiply, restoring shift-subtract for divide.
REQ-007 Latency: start sampled at edge E0; busy SHALL be 1 for exactly 32 cycles (E0..E32); at E32 hi/lo SHALL be written, state SHALL return to IDLE, and done SHALL be 1 for the single cycle following E32.
REQ-008 Multiply SHALL write the 64-bit product {hi,lo}; for mult, the product SHALL be two's-complement negated when the operand signs differ.
REQ-009 Divide SHALL write lo = quotient and hi = remainder; for div, the quotient SHALL be negated when the operand signs differ and the remainder SHALL take the sign of the dividend.
REQ-010 Divide by zero (b=0, div or divu) SHALL yield lo=0xFFFFFFFF and hi=a, with normal 32-cycle latency.
REQ-011 div 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000 (no trap).
REQ-012 flush=1 while busy SHALL return the block to IDLE at the next edge; hi/lo SHALL be unchanged and done SHALL not assert.
REQ-013 hi_we/lo_we SHALL write wdata to hi/lo at the next edge only while busy=0; they SHALL be ignored while busy=1.
REQ-014 hi_we and lo_we asserted together SHALL write both registers.
REQ-015 A write strobe and start in the same IDLE cycle SHALL both be honored; the write lands at E0, and the operation result later overwrites both registers at E32.
REQ-016 hi and lo SHALL change only at a result commit, a permitted write strobe, or reset.

Reset
REQ-017 resetn=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the iteration count, including mid-operation.
REQ-018 After reset deasserts, the first start SHALL behave per REQ-004 with no residual state.

Verification
REQ-019 multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 32 cycles; done pulse 1 cycle.
REQ-020 mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-021 div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-022 divu a=10 b=0 -> lo=0xFFFFFFFF, hi=0x0000000A.
REQ-023 hi=lo=0x12345678 preset via hi_we/lo_we; start mult 7*9, flush at cycle 10 -> hi=lo=0x12345678, no done, busy=0 next cycle; start during busy -> no effect on result or latency.
REQ-024 resetn pulsed low at cycle 15 of a divu -> busy=0, hi=lo=0 immediately; a fresh multu 3*4 afterwards -> lo=12, hi=0.
